// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared definitions for the instruction fetch queue: default widths, the
// credit pool depth, and the {pc, instr} entry type that decode consumes.
// No ports (package).
// ----------------------------------------------------------------------------
package ifetch_pkg;

    localparam int DEF_ADDR_W  = 72;
    localparam int DEF_INSTR_W = 72;
    localparam int DEF_DEPTH   = 4;

    // One fetched instruction as presented to decode.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// ----------------------------------------------------------------------------
// ifetch_queue_if
// Bundles every signal of the fetch stage except clock and reset:
//   PC side      : ce, pc, flush (in), fetch_stall (out)
//   imem request : imem_req_valid/addr (out), imem_req_ready (in)
//   imem response: imem_rsp_valid/data (in)
//   decode side  : if_valid/if_pc/if_instr (out), if_ready (in)
// master = the fetch queue, slave = its environment (PC, memory, decode).
// ----------------------------------------------------------------------------
interface ifetch_queue_if
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) ();

    logic               ce;
    logic [ADDR_W-1:0]  pc;
    logic               flush;
    logic               fetch_stall;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;

    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    logic               if_valid;
    logic               if_ready;
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instr;

    modport master (
        input  ce, pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output fetch_stall, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output ce, pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  fetch_stall, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Small register-based FIFO with a synchronous clear. Occupancy is tracked by
// the owner, which guarantees no push when full and no pop when empty.
//   clk, rst  : clock, synchronous active-high reset (pointers and storage)
//   clr       : drop all contents (pointers only)
//   push/wdata: write one entry
//   pop       : advance the read pointer
//   rdata     : current head, read straight from the storage registers
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is zeroed on reset so the head reads as zero until first use.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Fetch stage between the PC and decode. Issues in-order reads to instruction
// memory while credits remain, pairs each in-order response with the PC that
// requested it, and queues {pc, instr} for decode. A flush throws away queued
// and in-flight work; in-flight responses are counted down in discard_cnt.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ifetch_queue_if.master (PC, imem request/response, decode)
// ----------------------------------------------------------------------------
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INSTR_W;

    logic [CNT_W-1:0]   pend_cnt;
    logic [CNT_W-1:0]   q_cnt;
    logic [CNT_W-1:0]   discard_cnt;
    logic [CNT_W+1:0]   used;
    logic               credit;
    logic               req_fire;
    logic               rsp_take;
    logic               q_pop;
    logic [ADDR_W-1:0]  pend_pc;
    logic [ENT_W-1:0]   head;

    // Every credit covers either an outstanding request, a queued instruction
    // or a response still to be discarded, so a response always has a slot.
    assign used   = {2'b00, pend_cnt} + {2'b00, q_cnt} + {2'b00, discard_cnt};
    assign credit = (used < (CNT_W+2)'(DEPTH));

    assign bus.imem_req_valid = bus.ce & ~bus.flush & credit & ~rst;
    assign bus.imem_req_addr  = bus.pc;
    assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

    // PC holds whenever its request cannot fire; during a flush it must be
    // free to load the branch target.
    assign bus.fetch_stall = ~rst & bus.ce & ~bus.flush & ~(credit & bus.imem_req_ready);

    // Responses for wrong-path requests are dropped while discard_cnt > 0.
    assign rsp_take = bus.imem_rsp_valid & ~bus.flush & (discard_cnt == '0);

    assign bus.if_valid = (q_cnt != '0);
    assign q_pop        = bus.if_valid & bus.if_ready & ~bus.flush;
    assign bus.if_pc    = head[ENT_W-1:INSTR_W];
    assign bus.if_instr = head[INSTR_W-1:0];

    sync_fifo #(
        .DATA_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_pend_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush),
        .push  (req_fire),
        .pop   (rsp_take),
        .wdata (bus.pc),
        .rdata (pend_pc)
    );

    sync_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush),
        .push  (rsp_take),
        .pop   (q_pop),
        .wdata ({pend_pc, bus.imem_rsp_data}),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt    <= '0;
            q_cnt       <= '0;
            discard_cnt <= '0;
        end else if (bus.flush) begin
            // Everything still in flight becomes discard work; a response
            // arriving in the flush cycle itself is one fewer to wait for.
            pend_cnt    <= '0;
            q_cnt       <= '0;
            discard_cnt <= discard_cnt + pend_cnt - CNT_W'(bus.imem_rsp_valid);
        end else begin
            pend_cnt <= pend_cnt + CNT_W'(req_fire) - CNT_W'(rsp_take);
            q_cnt    <= q_cnt + CNT_W'(rsp_take) - CNT_W'(q_pop);
            if (bus.imem_rsp_valid && discard_cnt != '0)
                discard_cnt <= discard_cnt - 1'b1;
        end
    end

    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rsp_valid |-> (({1'b0, pend_cnt} + {1'b0, discard_cnt}) != '0));

    a_used_bound: assert property (@(posedge clk) disable iff (rst)
        used <= (CNT_W+2)'(DEPTH));

endmodule
